mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 32 +++
 rtl/mem_access_ctrl_lane_align.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access path: access sizes, controller
// states and the lane constants used by extract/merge.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Little-endian: byte offset k sits at bit 8k.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge of store
// data into a previously read word for sub-word stores.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] mem_word,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh         = lane_shift(offset);
    lane       = mem_word >> sh;
    mask       = '0;
    load_data  = mem_word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        mask       = BYTE_MASK << sh;
        load_data  = is_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        store_data = (mem_word & ~mask) | ((wdata & BYTE_MASK) << sh);
      end
      SZ_HALF: begin
        mask       = HALF_MASK << sh;
        load_data  = is_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        store_data = (mem_word & ~mask) | ((wdata & HALF_MASK) << sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the pipeline and a word-indexed data memory
// with one-cycle registered read; sub-word stores are read-modify-write.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  // Request: accepted on any rising edge where req_valid && req_ready.
  // Response: rsp_valid is a one-cycle pulse; rsp_rdata/rsp_err hold otherwise.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  output state_e      dbg_state
);

  state_e      state_q;
  logic        write_q;
  size_e       size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  size_e       req_size_e;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready  = (state_q == IDLE);
  assign dbg_state  = state_q;
  assign req_size_e = size_e'(req_size);

  always_comb begin
    req_err = (word_index(req_addr) >= 32'(MEM_DEPTH));
    case (req_size_e)
      SZ_HALF: req_err = req_err | req_addr[0];
      SZ_WORD: req_err = req_err | (req_addr[1:0] != 2'b00);
      SZ_ILL:  req_err = 1'b1;
      default: ;
    endcase
  end

  // Read_data is only meaningful in CAP, the cycle after the MemRead strobe.
  mem_lane_align u_align (
    .mem_word    (Read_data),
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      Write_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Address   <= '0;
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            size_q  <= req_size_e;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_err) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_write && req_size_e == SZ_WORD) begin
              state_q    <= WR;
              MemWrite   <= 1'b1;
              Address    <= word_index(req_addr);
              Write_data <= req_wdata;
            end else begin
              state_q <= RD;
              MemRead <= 1'b1;
              Address <= word_index(req_addr);
            end
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          if (write_q) begin
            state_q    <= WR;
            MemWrite   <= 1'b1;
            Address    <= word_index(addr_q);
            Write_data <= merge_data;
          end else begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        WR: begin
          state_q   <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic, checked
// against a byte-addressed reference memory.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  state_e      dbg_state;

  mem_access_ctrl #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: registered read, preloaded on the first edge
  logic [31:0] mem [DEPTH];
  bit          mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i < 6) ? 32'(i) : 32'h0;
      mem_init <= 1'b0;
    end else begin
      if (MemRead)  Read_data <= mem[Address[4:0]];
      if (MemWrite) mem[Address[4:0]] <= Write_data;
    end
  end

  // Reference model: byte-addressed memory
  logic [7:0] ref_bytes [DEPTH*4];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    int n = 1 << sz;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Driver: one request, waits for its response; starts and ends on a negedge
  task automatic do_req(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int t_acc, nrd, nwr, guard, exp_lat, bad_strobe;
    bit e;
    logic [31:0] exp_rd, exp_wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    e       = ref_err(sz, a);
    exp_lat = e ? 1 : (!wr ? 3 : (sz == 2'b10 ? 2 : 4));
    exp_rd  = (!e && !wr) ? ref_load(sz, uns, a) : 32'h0;
    if (!e && wr) ref_store(sz, a, wd);
    exp_wd  = (!e && wr) ? ref_word(int'(a >> 2)) : 32'h0;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    t_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    nrd = 0; nwr = 0; bad_strobe = 0; guard = 0;
    while (!rsp_valid && guard < 10) begin
      if (MemRead) begin
        nrd++;
        if (Address !== (a >> 2)) bad_strobe++;
      end
      if (MemWrite) begin
        nwr++;
        if (Address !== (a >> 2) || Write_data !== exp_wd) bad_strobe++;
      end
      @(negedge clk);
      guard++;
    end
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " latency"}, 32'(cyc - t_acc), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata, exp_rd);
    check({tag, " err"}, 32'(rsp_err), 32'(e));
    check({tag, " reads"}, 32'(nrd), (!e && !(wr && sz == 2'b10)) ? 32'd1 : 32'd0);
    check({tag, " writes"}, 32'(nwr), (!e && wr) ? 32'd1 : 32'd0);
    check({tag, " strobe addr/data"}, 32'(bad_strobe), 32'd0);
    if (!e && wr) check({tag, " mem word"}, mem[(a >> 2) & 32'h1F], exp_wd);
    @(negedge clk);
    check({tag, " hold rdata"}, rsp_rdata, exp_rd);
    check({tag, " hold err"}, 32'(rsp_err), 32'(e));
  endtask

  int seen, r1, r2, acc2, ta;
  logic [31:0] d1, d2, exp_b;

  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = (b == 0 && i < 6) ? 8'(i) : 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst MemRead", 32'(MemRead), 32'd0);
    check("rst MemWrite", 32'(MemWrite), 32'd0);
    check("rst Address", Address, 32'd0);
    check("rst Write_data", Write_data, 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    do_req("lw 0x14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    check("lw 0x14 value", rsp_rdata, 32'h0000_0005);
    do_req("sw 0x08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
    do_req("lb 0x0B", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0);
    check("lb 0x0B value", rsp_rdata, 32'hFFFF_FFDE);
    do_req("lbu 0x0B", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
    check("lbu 0x0B value", rsp_rdata, 32'h0000_00DE);
    do_req("sh 0x06", 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_ABCD);
    check("sh 0x06 word1", mem[1], 32'hABCD_0001);
    do_req("lw 0x02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    do_req("lh 0x01", 1'b0, 2'b01, 1'b0, 32'h01, 32'h0);
    do_req("lw 0x80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    do_req("size 11", 1'b1, 2'b11, 1'b0, 32'h04, 32'h1234_5678);
    do_req("lw 0x7C", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0);

    // Reset during CAP of a byte store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000_00AA;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (MemWrite || rsp_valid || MemRead) seen++;
    end
    check("midrst Address", Address, 32'd0);
    check("midrst rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    if (MemWrite || rsp_valid) seen++;
    check("midrst ready after release", 32'(req_ready), 32'd1);
    repeat (3) begin
      if (MemWrite || rsp_valid) seen++;
      @(negedge clk);
    end
    check("midrst no strobe/rsp", 32'(seen), 32'd0);
    check("midrst word4 unchanged", mem[4], ref_word(4));

    // Request held across a busy load, then a second one queued behind it
    exp_b = ref_load(2'b01, 1'b0, 32'h08);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h0;
    ta = cyc; r1 = -1; r2 = -1; acc2 = -1; d1 = '0; d2 = '0;
    @(negedge clk);
    req_size = 2'b01; req_addr = 32'h08;
    for (int k = 0; k < 14; k++) begin
      if (rsp_valid) begin
        if (r1 < 0) begin r1 = cyc; d1 = rsp_rdata; end
        else begin r2 = cyc; d2 = rsp_rdata; end
      end
      if (req_ready && req_valid && acc2 < 0) acc2 = cyc;
      else if (acc2 >= 0) req_valid = 1'b0;
      if (r2 >= 0) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b first latency", 32'(r1 - ta), 32'd3);
    check("b2b first data", d1, ref_word(3));
    check("b2b second accept", 32'(acc2 - ta), 32'd4);
    check("b2b second latency", 32'(r2 - acc2), 32'd3);
    check("b2b second data", d2, exp_b);
    @(negedge clk);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, DEPTH * 4 + 15));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
